float_mult_pipe: RTL and testbench

Parametrised, three-stage pipelined IEEE-754 binary floating-point multiplier with valid/ready flow control, selectable rounding (RNE/RTZ), exception flags and a pass-through tag. It sits in the FPU execute path, replacing the single-cycle, half-precision-only multiplier. It adds correct exponent biasing, rounding, signed zeros and backpressure. Defaults give binary16; EXP_W=8, FRAC_W=23 gives binary32.

---
 rtl/fpu_types_pkg.sv | 25 ++
 rtl/float_mult_round.sv | 56 +++++
 rtl/float_mult_pipe.sv | 156 +++++++++++++++
 tb/tb_float_mult_pipe.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_types_pkg.sv
// Shared FPU types: rounding mode, exception flag bundle and operand class.
package fpu_types_pkg;

    typedef enum logic {
        RNE = 1'b0,
        RTZ = 1'b1
    } round_mode_t;

    typedef struct packed {
        logic invalid;
        logic div0;
        logic overflow;
        logic underflow;
        logic inexact;
    } fpu_flags_t;

    typedef enum logic [2:0] {
        ZERO,
        NORM,
        INF,
        QNAN,
        SNAN
    } fp_class_t;

endpackage

// File: rtl/float_mult_round.sv
// Combinational normalize/round/pack stage shared by the FP multiplier and adder.
module float_mult_round
    import fpu_types_pkg::*;
#(
    parameter int unsigned EXP_W  = 5,
    parameter int unsigned FRAC_W = 10
) (
    input  logic                      sign,
    input  logic signed [EXP_W+1:0]   exp_in,
    input  logic [2*FRAC_W+1:0]       prod,
    input  round_mode_t               rnd_mode,
    output logic [EXP_W+FRAC_W:0]     result,
    output fpu_flags_t                flags
);

    localparam int unsigned PROD_W = 2 * FRAC_W + 2;
    localparam logic signed [EXP_W+1:0] EXP_MAX  = (EXP_W+2)'((1 << EXP_W) - 1);
    localparam logic signed [EXP_W+1:0] EXP_ZERO = '0;

    logic                    hi;
    logic [FRAC_W-1:0]       kept;
    logic                    guard;
    logic                    sticky;
    logic                    inc;
    logic [FRAC_W:0]         frac_r;
    logic signed [EXP_W+1:0] exp_n;
    logic signed [EXP_W+1:0] exp_r;

    always_comb begin
        hi     = prod[PROD_W-1];
        exp_n  = exp_in + $signed({{(EXP_W+1){1'b0}}, hi});
        kept   = hi ? prod[PROD_W-2 -: FRAC_W] : prod[PROD_W-3 -: FRAC_W];
        guard  = hi ? prod[FRAC_W] : prod[FRAC_W-1];
        sticky = hi ? |prod[FRAC_W-1:0] : |prod[FRAC_W-2:0];
        inc    = (rnd_mode == RNE) && guard && (sticky || kept[0]);
        // A carry out of the rounded fraction leaves it all-zero; only the exponent moves.
        frac_r = {1'b0, kept} + (FRAC_W+1)'(inc);
        exp_r  = exp_n + $signed({{(EXP_W+1){1'b0}}, frac_r[FRAC_W]});

        flags         = '0;
        flags.inexact = guard | sticky;
        result        = {sign, exp_r[EXP_W-1:0], frac_r[FRAC_W-1:0]};

        if (exp_r >= EXP_MAX) begin
            flags.overflow = 1'b1;
            flags.inexact  = 1'b1;
            result = (rnd_mode == RTZ) ? {sign, {(EXP_W-1){1'b1}}, 1'b0, {FRAC_W{1'b1}}}
                                       : {sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
        end else if (exp_r <= EXP_ZERO) begin
            flags.underflow = 1'b1;
            flags.inexact   = 1'b1;
            result = {sign, {(EXP_W+FRAC_W){1'b0}}};
        end
    end

endmodule

// File: rtl/float_mult_pipe.sv
// Three-stage elastic IEEE-754 multiplier: classify/exponent, mantissa multiply, round/pack.
module float_mult_pipe
    import fpu_types_pkg::*;
#(
    parameter int unsigned EXP_W  = 5,
    parameter int unsigned FRAC_W = 10,
    parameter int unsigned TAG_W  = 4
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+FRAC_W:0]  float1,
    input  logic [EXP_W+FRAC_W:0]  float2,
    input  round_mode_t            rnd_mode,
    input  logic [TAG_W-1:0]       in_tag,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+FRAC_W:0]  product,
    output fpu_flags_t             flags,
    output logic [TAG_W-1:0]       out_tag
);

    localparam int unsigned FLOAT_W = 1 + EXP_W + FRAC_W;
    localparam int unsigned PROD_W  = 2 * FRAC_W + 2;
    localparam logic signed [EXP_W+1:0] BIAS = (EXP_W+2)'((1 << (EXP_W - 1)) - 1);
    localparam logic [FLOAT_W-1:0] QNAN_C = {1'b0, {EXP_W{1'b1}}, 1'b1, {(FRAC_W-1){1'b0}}};

    function automatic fp_class_t classify(input logic [FLOAT_W-1:0] f);
        logic [EXP_W-1:0]  e;
        logic [FRAC_W-1:0] m;
        e = f[FLOAT_W-2 -: EXP_W];
        m = f[FRAC_W-1:0];
        if (e == '0)                 return ZERO;
        else if (e != '1)            return NORM;
        else if (m == '0)            return INF;
        else if (m[FRAC_W-1])        return QNAN;
        else                         return SNAN;
    endfunction

    // Elastic handshake: a stage loads when empty or when the stage after it advances.
    logic ld1, ld2, ld3;
    logic v1, v2, v3;

    assign ld3       = ~v3 | out_ready;
    assign ld2       = ~v2 | ld3;
    assign ld1       = ~v1 | ld2;
    assign in_ready  = ld1;
    assign out_valid = v3;

    fp_class_t               c1, c2;
    logic                    s_sign, s_special, s_invalid;
    logic signed [EXP_W+1:0] s_exp;
    logic [FLOAT_W-1:0]      s_res;

    always_comb begin
        c1        = classify(float1);
        c2        = classify(float2);
        s_sign    = float1[FLOAT_W-1] ^ float2[FLOAT_W-1];
        s_exp     = $signed({2'b00, float1[FLOAT_W-2 -: EXP_W]})
                  + $signed({2'b00, float2[FLOAT_W-2 -: EXP_W]}) - BIAS;
        s_special = 1'b1;
        s_invalid = 1'b0;
        s_res     = QNAN_C;
        if (c1 == QNAN || c1 == SNAN || c2 == QNAN || c2 == SNAN) begin
            s_invalid = (c1 == SNAN) || (c2 == SNAN);
        end else if ((c1 == INF && c2 == ZERO) || (c1 == ZERO && c2 == INF)) begin
            s_invalid = 1'b1;
        end else if (c1 == INF || c2 == INF) begin
            s_res = {s_sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
        end else if (c1 == ZERO || c2 == ZERO) begin
            s_res = {s_sign, {(EXP_W+FRAC_W){1'b0}}};
        end else begin
            s_special = 1'b0;
        end
    end

    logic                    r1_sign, r1_special, r1_invalid;
    logic signed [EXP_W+1:0] r1_exp;
    logic [FRAC_W:0]         r1_m1, r1_m2;
    logic [FLOAT_W-1:0]      r1_res;
    round_mode_t             r1_rnd;
    logic [TAG_W-1:0]        r1_tag;

    logic                    r2_sign, r2_special, r2_invalid;
    logic signed [EXP_W+1:0] r2_exp;
    logic [PROD_W-1:0]       r2_prod;
    logic [FLOAT_W-1:0]      r2_res;
    round_mode_t             r2_rnd;
    logic [TAG_W-1:0]        r2_tag;

    logic [FLOAT_W-1:0]      rnd_res;
    fpu_flags_t              rnd_flags;

    float_mult_round #(
        .EXP_W  (EXP_W),
        .FRAC_W (FRAC_W)
    ) u_round (
        .sign     (r2_sign),
        .exp_in   (r2_exp),
        .prod     (r2_prod),
        .rnd_mode (r2_rnd),
        .result   (rnd_res),
        .flags    (rnd_flags)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            v1 <= 1'b0;  v2 <= 1'b0;  v3 <= 1'b0;
            r1_sign <= 1'b0;  r1_special <= 1'b0;  r1_invalid <= 1'b0;
            r1_exp <= '0;  r1_m1 <= '0;  r1_m2 <= '0;  r1_res <= '0;
            r1_rnd <= RNE;  r1_tag <= '0;
            r2_sign <= 1'b0;  r2_special <= 1'b0;  r2_invalid <= 1'b0;
            r2_exp <= '0;  r2_prod <= '0;  r2_res <= '0;
            r2_rnd <= RNE;  r2_tag <= '0;
            product <= '0;  flags <= '0;  out_tag <= '0;
        end else begin
            if (ld1) begin
                v1 <= in_valid;
                if (in_valid) begin
                    r1_sign    <= s_sign;
                    r1_special <= s_special;
                    r1_invalid <= s_invalid;
                    r1_exp     <= s_exp;
                    r1_m1      <= {1'b1, float1[FRAC_W-1:0]};
                    r1_m2      <= {1'b1, float2[FRAC_W-1:0]};
                    r1_res     <= s_res;
                    r1_rnd     <= rnd_mode;
                    r1_tag     <= in_tag;
                end
            end
            if (ld2) begin
                v2 <= v1;
                if (v1) begin
                    r2_sign    <= r1_sign;
                    r2_special <= r1_special;
                    r2_invalid <= r1_invalid;
                    r2_exp     <= r1_exp;
                    r2_prod    <= r1_m1 * r1_m2;
                    r2_res     <= r1_res;
                    r2_rnd     <= r1_rnd;
                    r2_tag     <= r1_tag;
                end
            end
            if (ld3) begin
                v3 <= v2;
                if (v2) begin
                    product <= r2_special ? r2_res : rnd_res;
                    flags   <= r2_special ? fpu_flags_t'({r2_invalid, 4'b0000}) : rnd_flags;
                    out_tag <= r2_tag;
                end
            end
        end
    end

endmodule

// File: tb/tb_float_mult_pipe.sv
// Bench for float_mult_pipe: arithmetic reference model, scoreboard compare, directed vectors.
module tb_float_mult_pipe;
    import fpu_types_pkg::*;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [15:0] float1, float2, product;
    round_mode_t rnd_mode;
    logic [3:0]  in_tag, out_tag;
    fpu_flags_t  flags;

    logic        b_in_valid, b_in_ready, b_out_valid;
    logic [31:0] b_float1, b_float2, b_product;
    logic [3:0]  b_out_tag;
    fpu_flags_t  b_flags;

    int errors = 0;
    int checks = 0;
    logic [3:0] tag_ctr = '0;

    typedef struct packed {
        logic [3:0]  tag;
        logic [4:0]  flg;
        logic [15:0] prod;
    } exp_t;
    exp_t sb[$];

    always #5 CLK = ~CLK;

    float_mult_pipe #(.EXP_W(5), .FRAC_W(10), .TAG_W(4)) dut (
        .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready),
        .float1(float1), .float2(float2), .rnd_mode(rnd_mode), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .product(product),
        .flags(flags), .out_tag(out_tag)
    );

    float_mult_pipe #(.EXP_W(8), .FRAC_W(23), .TAG_W(4)) dut32 (
        .CLK(CLK), .RST(RST), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .float1(b_float1), .float2(b_float2), .rnd_mode(RNE), .in_tag(4'h5),
        .out_valid(b_out_valid), .out_ready(1'b1), .product(b_product),
        .flags(b_flags), .out_tag(b_out_tag)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Exact binary16 product via integer significands and remainder-vs-half rounding.
    function automatic logic [20:0] model(input logic [15:0] a, input logic [15:0] b, input logic rtz);
        int unsigned ea, eb, fa, fb, p, q, rem, half, sh;
        int e;
        logic s, nana, nanb, sna, snb, inx;
        ea = int'(a[14:10]);  eb = int'(b[14:10]);
        fa = int'(a[9:0]);    fb = int'(b[9:0]);
        nana = (ea == 31) && (fa != 0);  sna = nana && !a[9];
        nanb = (eb == 31) && (fb != 0);  snb = nanb && !b[9];
        s = a[15] ^ b[15];
        if (nana || nanb) return {sna || snb, 4'b0000, 16'h7E00};
        if ((ea == 31 && eb == 0) || (ea == 0 && eb == 31)) return {5'b10000, 16'h7E00};
        if (ea == 31 || eb == 31) return {5'b00000, s, 15'h7C00};
        if (ea == 0 || eb == 0) return {5'b00000, s, 15'h0000};
        p    = (1024 + fa) * (1024 + fb);
        sh   = (p >= (1 << 21)) ? 11 : 10;
        q    = p >> sh;
        rem  = p - (q << sh);
        half = 1 << (sh - 1);
        e    = int'(ea + eb) - 15 + int'(sh) - 10;
        inx  = (rem != 0);
        if (!rtz && (rem > half || (rem == half && q[0]))) q++;
        if (q == 2048) begin q = 1024; e++; end
        if (e >= 31) return {5'b00101, s, rtz ? 15'h7BFF : 15'h7C00};
        if (e <= 0)  return {5'b00011, s, 15'h0000};
        return {4'b0000, inx, s, e[4:0], q[9:0]};
    endfunction

    task automatic issue(input logic [15:0] a, input logic [15:0] b, input round_mode_t rm);
        logic ok;
        in_valid = 1'b1;  float1 = a;  float2 = b;  rnd_mode = rm;  in_tag = tag_ctr;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge CLK);
            ok = in_ready;
            @(posedge CLK);
            #1;
        end
        in_valid = 1'b0;
        tag_ctr++;
        chk("accept", {31'd0, ok}, 32'd1);
    endtask

    // {a, b, rtz, expected product, expected flags}
    localparam int NV = 14;
    localparam logic [53:0] VEC [NV] = '{
        {16'h3E00, 16'h4000, 1'b0, 16'h4200, 5'b00000},
        {16'h3C01, 16'h3E00, 1'b0, 16'h3E02, 5'b00001},
        {16'h3C01, 16'h3E00, 1'b1, 16'h3E01, 5'b00001},
        {16'h3C01, 16'h3C01, 1'b0, 16'h3C02, 5'b00001},
        {16'h7BFF, 16'h4000, 1'b0, 16'h7C00, 5'b00101},
        {16'h7BFF, 16'h4000, 1'b1, 16'h7BFF, 5'b00101},
        {16'h0400, 16'h0400, 1'b0, 16'h0000, 5'b00011},
        {16'h8400, 16'h0400, 1'b0, 16'h8000, 5'b00011},
        {16'h7C00, 16'h0000, 1'b0, 16'h7E00, 5'b10000},
        {16'h7D00, 16'h3C00, 1'b0, 16'h7E00, 5'b10000},
        {16'hFC00, 16'h3C00, 1'b0, 16'hFC00, 5'b00000},
        {16'h8000, 16'h3C00, 1'b0, 16'h8000, 5'b00000},
        {16'h7E00, 16'hC000, 1'b0, 16'h7E00, 5'b00000},
        {16'h0001, 16'h3C00, 1'b0, 16'h0000, 5'b00000}
    };

    initial begin
        logic [53:0] v;
        time t0;
        int lat;
        logic done;
        in_valid = 1'b0;  out_ready = 1'b1;  float1 = '0;  float2 = '0;
        rnd_mode = RNE;   in_tag = '0;
        b_in_valid = 1'b0;  b_float1 = '0;  b_float2 = '0;

        fork
            forever begin
                @(negedge CLK);
                if (!RST) begin
                    if (out_valid) begin
                        if (sb.size() == 0) begin
                            chk("spurious out_valid", {31'd0, out_valid}, 32'd0);
                        end else begin
                            chk("product", {16'd0, product}, {16'd0, sb[0].prod});
                            chk("flags", {27'd0, flags}, {27'd0, sb[0].flg});
                            chk("out_tag", {28'd0, out_tag}, {28'd0, sb[0].tag});
                            if (out_ready) void'(sb.pop_front());
                        end
                    end
                    if (in_valid && in_ready)
                        sb.push_back({in_tag, model(float1, float2, rnd_mode == RTZ)});
                end
            end
        join_none

        #1 RST = 1'b1;
        #11;
        chk("reset out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset product", {16'd0, product}, 32'd0);
        chk("reset flags", {27'd0, flags}, 32'd0);
        chk("reset out_tag", {28'd0, out_tag}, 32'd0);
        @(posedge CLK); #1 RST = 1'b0;
        @(posedge CLK); #1;
        chk("in_ready after reset", {31'd0, in_ready}, 32'd1);

        // Single op: out_valid in the third cycle after the accepting edge.
        issue(16'h3E00, 16'h4000, RNE);
        lat = 0;
        for (int i = 1; i <= 10 && lat == 0; i++) begin
            @(negedge CLK);
            if (out_valid) lat = i;
        end
        chk("latency", lat, 32'd3);
        repeat (4) @(posedge CLK);
        #1;

        for (int i = 0; i < NV; i++) begin
            v = VEC[i];
            chk($sformatf("model pin %0d", i), {11'd0, model(v[53:38], v[37:22], v[21])},
                {11'd0, v[4:0], v[20:5]});
        end

        t0 = $time;
        for (int i = 0; i < NV; i++) begin
            v = VEC[i];
            issue(v[53:38], v[37:22], round_mode_t'(v[21]));
        end
        chk("throughput", 32'($time - t0), 32'(NV * 10));
        repeat (6) @(posedge CLK);
        #1;
        chk("drained after burst", sb.size(), 32'd0);

        out_ready = 1'b0;
        issue(16'h3C00, 16'h4000, RNE);
        issue(16'h4000, 16'h4200, RNE);
        issue(16'hC200, 16'h3C01, RTZ);
        in_valid = 1'b1;  float1 = 16'h3555;  float2 = 16'h4248;  rnd_mode = RNE;  in_tag = tag_ctr;
        repeat (3) begin
            @(negedge CLK);
            chk("in_ready under backpressure", {31'd0, in_ready}, 32'd0);
        end
        @(posedge CLK); #1;
        out_ready = 1'b1;
        issue(16'h3555, 16'h4248, RNE);
        issue(16'h5BFF, 16'h5000, RTZ);
        repeat (6) @(posedge CLK);
        #1;
        chk("drained after backpressure", sb.size(), 32'd0);

        issue(16'h4100, 16'h4100, RNE);
        issue(16'h3800, 16'h3800, RNE);
        issue(16'h4400, 16'hBC00, RNE);
        #1 RST = 1'b1;
        #1;
        chk("mid-flight reset out_valid", {31'd0, out_valid}, 32'd0);
        chk("mid-flight reset product", {16'd0, product}, 32'd0);
        chk("mid-flight reset flags", {27'd0, flags}, 32'd0);
        sb.delete();
        repeat (2) @(posedge CLK);
        #1 RST = 1'b0;
        @(posedge CLK); #1;
        chk("in_ready after mid reset", {31'd0, in_ready}, 32'd1);
        repeat (6) @(posedge CLK);
        #1;
        chk("no stale results", sb.size(), 32'd0);

        b_in_valid = 1'b1;  b_float1 = 32'h3FC00000;  b_float2 = 32'h40000000;
        done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge CLK);
            done = b_in_ready;
            @(posedge CLK); #1;
        end
        b_in_valid = 1'b0;
        done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge CLK);
            done = b_out_valid;
        end
        chk("fp32 out_valid", {31'd0, done}, 32'd1);
        chk("fp32 product", b_product, 32'h40400000);
        chk("fp32 flags", {27'd0, b_flags}, 32'd0);
        chk("fp32 out_tag", {28'd0, b_out_tag}, 32'd5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
